// File: rtl/serial_arbiter_if.sv
// serial_arbiter_if: bundles the requester, response and serial-unit
// signals of serial_arbiter.
//   req0_* / req1_*  operand handshakes from the two requesters
//   resp_*           tagged result handshake to the consumer
//   su_*             operand/start/result link to the shared serial_top
// The slave modport is the arbiter's view. The master modport is the
// surrounding logic: the clients, the consumer and the serial unit.
interface serial_arbiter_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [BIT_WIDTH-1:0] req0_A;
    logic [BIT_WIDTH-1:0] req0_B;
    logic                 req0_M;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [BIT_WIDTH-1:0] req1_A;
    logic [BIT_WIDTH-1:0] req1_B;
    logic                 req1_M;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [BIT_WIDTH:0]   resp_sum;
    logic                 resp_id;
    logic [BIT_WIDTH-1:0] su_A;
    logic [BIT_WIDTH-1:0] su_B;
    logic                 su_M;
    logic                 su_start;
    logic [BIT_WIDTH:0]   su_sum;

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_M,
        input  req1_valid, req1_A, req1_B, req1_M,
        input  resp_ready, su_sum,
        output req0_ready, req1_ready,
        output resp_valid, resp_sum, resp_id,
        output su_A, su_B, su_M, su_start
    );

    modport master (
        output req0_valid, req0_A, req0_B, req0_M,
        output req1_valid, req1_A, req1_B, req1_M,
        output resp_ready, su_sum,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_sum, resp_id,
        input  su_A, su_B, su_M, su_start
    );
endinterface

// File: rtl/serial_arbiter.sv
// serial_arbiter: shares one serial adder/subtractor between two requesters.
// Round-robin grant, operand latch, one-cycle start pulse, fixed-latency
// wait, then the captured result is returned tagged with the requester id.
//   clock   rising-edge clock, shared with serial_top
//   resetn  asynchronous active-low reset
//   bus     serial_arbiter_if.slave (requesters, response, serial unit)
//   busy    high whenever the FSM is not in IDLE
module serial_arbiter #(
    parameter int BIT_WIDTH = 8,
    parameter int LATENCY   = BIT_WIDTH + 2
) (
    input  logic                clock,
    input  logic                resetn,
    serial_arbiter_if.slave     bus,
    output logic                busy
);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic [BIT_WIDTH-1:0] su_a_q, su_a_d;
    logic [BIT_WIDTH-1:0] su_b_q, su_b_d;
    logic                 su_m_q, su_m_d;
    logic [BIT_WIDTH:0]   resp_sum_q, resp_sum_d;
    logic                 resp_id_q, resp_id_d;
    logic                 id_q, id_d;
    logic                 last_grant_q, last_grant_d;

    logic any_valid;
    logic grant;
    logic accept;

    // A contested grant goes to whoever was not served last. last_grant
    // resets to 1 so that requester 0 wins the first contest.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign accept    = (state_q == IDLE) & any_valid;

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;
    assign bus.su_A       = su_a_q;
    assign bus.su_B       = su_b_q;
    assign bus.su_M       = su_m_q;
    assign bus.su_start   = (state_q == ISSUE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_id    = resp_id_q;
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        su_a_d       = su_a_q;
        su_b_d       = su_b_q;
        su_m_d       = su_m_q;
        resp_sum_d   = resp_sum_q;
        resp_id_d    = resp_id_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    su_a_d  = grant ? bus.req1_A : bus.req0_A;
                    su_b_d  = grant ? bus.req1_B : bus.req0_B;
                    su_m_d  = grant ? bus.req1_M : bus.req0_M;
                    id_d    = grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                counter_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // The result is sampled on the LATENCY-th edge after the
                // start-cycle edge, which is when the count reaches LATENCY-1.
                counter_d = counter_q + 1'b1;
                if (counter_q == CNT_W'(LATENCY - 1)) begin
                    resp_sum_d = bus.su_sum;
                    resp_id_d  = id_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            su_a_q       <= '0;
            su_b_q       <= '0;
            su_m_q       <= 1'b0;
            resp_sum_q   <= '0;
            resp_id_q    <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            su_a_q       <= su_a_d;
            su_b_q       <= su_b_d;
            su_m_q       <= su_m_d;
            resp_sum_q   <= resp_sum_d;
            resp_id_q    <= resp_id_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_serial_arbiter.sv
// Bench for serial_arbiter. It includes a behavioural serial unit and a
// scoreboard. Expected results are queued when a request is accepted.
// The negedge monitor checks grants, busy and su_start against a small
// model, and it pops and compares every response handshake.
module tb_serial_arbiter;
    localparam int BW  = 8;
    localparam int LAT = BW + 2;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic busy;

    serial_arbiter_if #(.BIT_WIDTH(BW)) bus ();

    serial_arbiter #(.BIT_WIDTH(BW), .LATENCY(LAT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        id;
        logic [BW:0] sum;
    } resp_t;

    resp_t       sb[$];
    logic [BW:0] log_sum[$];
    logic        log_id[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt_id0  = 0;
    int          cnt_id1  = 0;
    logic        tb_busy    = 1'b0;
    logic        model_last = 1'b1;
    logic        start_exp  = 1'b0;
    logic        e0, e1;
    logic        rnd_done;
    resp_t       popped;

    function automatic logic [BW:0] calc(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                         input logic m);
        return m ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural serial unit. su_sum holds the true result only around the
    // LATENCY-th edge after the start edge, so a capture made too early or
    // too late picks up the inverted value instead.
    int   su_e;
    logic su_run;
    logic [BW:0] su_res;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bus.su_sum <= '0;
            su_run     <= 1'b0;
            su_e       <= 0;
            su_res     <= '0;
        end else if (bus.su_start) begin
            su_res     <= calc(bus.su_A, bus.su_B, bus.su_M);
            bus.su_sum <= ~calc(bus.su_A, bus.su_B, bus.su_M);
            su_e       <= 0;
            su_run     <= 1'b1;
        end else if (su_run) begin
            su_e <= su_e + 1;
            if (su_e + 1 == LAT - 1) bus.su_sum <= su_res;
            else if (su_e + 1 == LAT) begin
                bus.su_sum <= ~su_res;
                su_run     <= 1'b0;
            end
        end
    end

    // Monitor and scoreboard.
    always @(negedge clock) begin
        if (!resetn) begin
            sb.delete();
            tb_busy    = 1'b0;
            model_last = 1'b1;
            start_exp  = 1'b0;
        end else begin
            chk("busy", 32'(busy), 32'(tb_busy));
            chk("su_start", 32'(bus.su_start), 32'(start_exp));
            e0 = !tb_busy && bus.req0_valid && (!bus.req1_valid || model_last);
            e1 = !tb_busy && bus.req1_valid && (!bus.req0_valid || !model_last);
            chk("readys", 32'({bus.req1_ready, bus.req0_ready}), 32'({e1, e0}));
            start_exp = 1'b0;
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back('{id: 1'b0, sum: calc(bus.req0_A, bus.req0_B, bus.req0_M)});
                tb_busy   = 1'b1;
                start_exp = 1'b1;
            end else if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back('{id: 1'b1, sum: calc(bus.req1_A, bus.req1_B, bus.req1_M)});
                tb_busy   = 1'b1;
                start_exp = 1'b1;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got id %0d sum %0h, expected no response",
                             bus.resp_id, bus.resp_sum);
                end else begin
                    popped = sb.pop_front();
                    chk("resp_sum", 32'(bus.resp_sum), 32'(popped.sum));
                    chk("resp_id", 32'(bus.resp_id), 32'(popped.id));
                    log_sum.push_back(bus.resp_sum);
                    log_id.push_back(bus.resp_id);
                    if (popped.id) cnt_id1++;
                    else cnt_id0++;
                    model_last = popped.id;
                    tb_busy    = 1'b0;
                end
            end
        end
    end

    // Presents one request and holds it until it is accepted. The caller
    // invokes this just after a rising edge, and the task returns #1 after
    // the accept edge.
    task automatic drive(input int n, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic m);
        int   t = 0;
        logic rdy = 1'b0;
        if (n == 0) begin
            bus.req0_A = a; bus.req0_B = b; bus.req0_M = m; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_A = a; bus.req1_B = b; bus.req1_M = m; bus.req1_valid = 1'b1;
        end
        while (!rdy && t < 400) begin
            @(negedge clock);
            t++;
            rdy = (n == 0) ? bus.req0_ready : bus.req1_ready;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL req%0d_grant_timeout: got no ready in %0d cycles, expected a grant", n, t);
        end else begin
            @(posedge clock);
            #1;
        end
        if (n == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        if (t >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", t);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 resetn = 1'b0;
        repeat (3) @(posedge clock);
        #2 resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        bus.req0_valid = 0; bus.req0_A = 0; bus.req0_B = 0; bus.req0_M = 0;
        bus.req1_valid = 0; bus.req1_A = 0; bus.req1_B = 0; bus.req1_M = 0;
        bus.resp_ready = 1'b1;
        rnd_done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        // Reset state: the bench is still holding reset here.
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst su_start", 32'(bus.su_start), 32'd0);
        chk("rst su_A", 32'(bus.su_A), 32'd0);
        chk("rst resp_sum", 32'(bus.resp_sum), 32'd0);
        #1 resetn = 1'b1;
        @(posedge clock);
        #1;

        // 1: a single add from requester 0, with exact handshake timing.
        bus.req0_A = 8'd100; bus.req0_B = 8'd27; bus.req0_M = 1'b0; bus.req0_valid = 1'b1;
        @(negedge clock);
        chk("t1 req0_ready", 32'(bus.req0_ready), 32'd1);
        @(posedge clock);
        #1 bus.req0_valid = 1'b0;
        chk("t1 su_start", 32'(bus.su_start), 32'd1);
        chk("t1 su_A", 32'(bus.su_A), 32'd100);
        chk("t1 su_B", 32'(bus.su_B), 32'd27);
        edges = 1;
        while (!bus.resp_valid && edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
        end
        chk("t1 accept_to_resp_edges", 32'(edges), 32'(LAT + 2));
        wait_idle();
        chk("t1 sum", 32'(log_sum[$]), 32'd127);
        chk("t1 id", 32'(log_id[$]), 32'd0);

        // 2: a subtract from requester 1. It wraps modulo 2^9.
        @(posedge clock);
        #1 drive(1, 8'd5, 8'd10, 1'b1);
        wait_idle();
        chk("t2 sum", 32'(log_sum[$]), 32'h1FB);
        chk("t2 id", 32'(log_id[$]), 32'd1);

        // 3: both requesters contend from reset. Grants alternate 0,1,0,1.
        do_reset();
        log_sum.delete(); log_id.delete();
        fork
            begin drive(0, 8'd255, 8'd255, 1'b0); drive(0, 8'd255, 8'd255, 1'b0); end
            begin drive(1, 8'd255, 8'd255, 1'b0); drive(1, 8'd255, 8'd255, 1'b0); end
        join
        wait_idle();
        chk("t3 count", 32'(log_sum.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_sum.size(); i++) begin
            chk("t3 sum", 32'(log_sum[i]), 32'd510);
            chk("t3 id", 32'(log_id[i]), 32'(i % 2));
        end

        // 4: response back-pressure while the other requester waits.
        @(posedge clock);
        #1 bus.resp_ready = 1'b0;
        drive(0, 8'd1, 8'd2, 1'b0);
        fork
            drive(1, 8'd7, 8'd3, 1'b1);
        join_none
        edges = 0;
        while (!bus.resp_valid && edges < 40) begin
            @(negedge clock);
            edges++;
        end
        repeat (20) begin
            @(negedge clock);
            chk("t4 resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("t4 resp_sum", 32'(bus.resp_sum), 32'd3);
            chk("t4 resp_id", 32'(bus.resp_id), 32'd0);
            chk("t4 readys", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        end
        @(posedge clock);
        #1 bus.resp_ready = 1'b1;
        wait fork;
        wait_idle();
        chk("t4 second sum", 32'(log_sum[$]), 32'd4);
        chk("t4 second id", 32'(log_id[$]), 32'd1);

        // 5: reset during WAIT aborts the operation without a response.
        @(posedge clock);
        #1 drive(0, 8'd10, 8'd20, 1'b0);
        repeat (4) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("t5 busy", 32'(busy), 32'd0);
        chk("t5 resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("t5 su_start", 32'(bus.su_start), 32'd0);
        chk("t5 su_A", 32'(bus.su_A), 32'd0);
        chk("t5 su_B", 32'(bus.su_B), 32'd0);
        chk("t5 su_M", 32'(bus.su_M), 32'd0);
        chk("t5 resp_sum", 32'(bus.resp_sum), 32'd0);
        chk("t5 resp_id", 32'(bus.resp_id), 32'd0);
        log_sum.delete(); log_id.delete();
        repeat (3) @(posedge clock);
        #2 resetn = 1'b1;
        @(posedge clock);
        #1;
        fork
            drive(0, 8'd200, 8'd100, 1'b1);
            drive(1, 8'd3, 8'd4, 1'b0);
        join
        wait_idle();
        chk("t5 count", 32'(log_sum.size()), 32'd2);
        if (log_sum.size() == 2) begin
            chk("t5 first id", 32'(log_id[0]), 32'd0);
            chk("t5 first sum", 32'(log_sum[0]), 32'd100);
            chk("t5 second id", 32'(log_id[1]), 32'd1);
            chk("t5 second sum", 32'(log_sum[1]), 32'd7);
        end

        // 6: random traffic with random back-pressure.
        cnt_id0 = 0; cnt_id1 = 0;
        @(posedge clock);
        #1;
        fork
            begin
                fork
                    for (int i = 0; i < 500; i++) begin
                        int k = $urandom_range(0, 3);
                        if (k > 0) begin repeat (k) @(posedge clock); #1; end
                        drive(0, 8'($urandom), 8'($urandom), 1'($urandom));
                    end
                    for (int j = 0; j < 500; j++) begin
                        int k = $urandom_range(0, 3);
                        if (k > 0) begin repeat (k) @(posedge clock); #1; end
                        drive(1, 8'($urandom), 8'($urandom), 1'($urandom));
                    end
                join
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clock);
                #1 bus.resp_ready = 1'($urandom);
            end
        join
        bus.resp_ready = 1'b1;
        wait_idle();
        chk("t6 req0 served", 32'(cnt_id0), 32'd500);
        chk("t6 req1 served", 32'(cnt_id1), 32'd500);
        chk("t6 scoreboard empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
